// File: rtl/kl10_cram_pkg.sv
// kl10_cram_pkg: shared CRAM loader constants, diagnostic function codes and FSM state encoding
package kl10_cram_pkg;
  localparam int CRAM_WIDTH  = 84;
  localparam int FIELD_WIDTH = 14;
  localparam int ADR_WIDTH   = 12;
  localparam int NFIELDS     = CRAM_WIDTH / FIELD_WIDTH;
  localparam logic [6:0] FN_LDADR  = 7'o50;
  localparam logic [6:0] FN_LDFLD0 = 7'o51;
  localparam logic [6:0] FN_LDFLD5 = 7'o56;
  localparam logic [6:0] FN_WRITE  = 7'o57;
  localparam logic [6:0] FN_RDFLD0 = 7'o60;
  localparam logic [6:0] FN_RDFLD5 = 7'o65;
  localparam logic [6:0] FN_CLRERR = 7'o66;
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_PARTIAL = 1;
  localparam int ERR_VERIFY  = 2;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VWAIT,
    ST_VCMP,
    ST_RWAIT,
    ST_RDONE
  } cram_state_e;
endpackage

// File: rtl/cram_loader.sv
// cram_loader: diagnostic-bus loader/reader for the CRAM port B; CRAM_LOADER_VERIFY_EN adds write read-back verify
module cram_loader
  import kl10_cram_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            DIAG_FUNC,
  input  logic                  DIAG_STROBE,
  input  logic [0:35]           EBUS_D,
  output logic [0:35]           EBUS_D_OUT,
  output logic                  EBUS_VALID,
  output logic [ADR_WIDTH-1:0]  CRAM_ADDRB,
  output logic [0:CRAM_WIDTH-1] CRAM_DINB,
  output logic                  CRAM_WEB,
  input  logic [0:CRAM_WIDTH-1] CRAM_DOUTB,
  output logic                  BUSY,
  output logic [2:0]            ERR
);
  cram_state_e              state_q;
  logic [ADR_WIDTH-1:0]     adr_q;
  logic [ADR_WIDTH-1:0]     addrb_q;
  logic [0:CRAM_WIDTH-1]    word_q;
  logic [NFIELDS-1:0]       mask_q;
  logic [2:0]               err_q;
  logic                     web_q;
  logic                     valid_q;
  logic [FIELD_WIDTH-1:0]   field_q;
  logic [2:0]               sel_q;
  logic                     is_ld;
  logic                     is_rd;
  logic [2:0]               ld_k;
  logic [2:0]               rd_k;
  logic                     unused_ebus;

  assign unused_ebus = ^EBUS_D[0:21];
  assign EBUS_D_OUT  = {22'b0, field_q};
  assign EBUS_VALID  = valid_q;
  assign CRAM_ADDRB  = addrb_q;
  assign CRAM_DINB   = word_q;
  assign CRAM_WEB    = web_q;
  assign BUSY        = state_q != ST_IDLE;
  assign ERR         = err_q;

  // Decode field-load and field-read function codes into a field index
  always_comb begin
    is_ld = DIAG_FUNC >= FN_LDFLD0 && DIAG_FUNC <= FN_LDFLD5;
    is_rd = DIAG_FUNC >= FN_RDFLD0 && DIAG_FUNC <= FN_RDFLD5;
    ld_k  = 3'(DIAG_FUNC - FN_LDFLD0);
    rd_k  = 3'(DIAG_FUNC - FN_RDFLD0);
  end

  // Command FSM with registered CRAM and EBUS outputs; strobes outside IDLE flag an overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      addrb_q <= '0;
      word_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      web_q   <= 1'b0;
      valid_q <= 1'b0;
      field_q <= '0;
      sel_q   <= '0;
    end else begin
      web_q   <= 1'b0;
      valid_q <= 1'b0;
      if (DIAG_STROBE && state_q != ST_IDLE) err_q[ERR_OVERRUN] <= 1'b1;
      case (state_q)
        ST_IDLE: if (DIAG_STROBE) begin
          if (DIAG_FUNC == FN_LDADR) begin
            adr_q  <= EBUS_D[24:35];
            mask_q <= '0;
          end else if (is_ld) begin
            word_q[ld_k*FIELD_WIDTH +: FIELD_WIDTH] <= EBUS_D[22:35];
            mask_q[ld_k] <= 1'b1;
          end else if (DIAG_FUNC == FN_WRITE) begin
            if (&mask_q) begin
              state_q <= ST_WRITE;
              web_q   <= 1'b1;
              addrb_q <= adr_q;
            end else begin
              err_q[ERR_PARTIAL] <= 1'b1;
            end
          end else if (is_rd) begin
            addrb_q <= adr_q;
            sel_q   <= rd_k;
            state_q <= ST_RWAIT;
          end else if (DIAG_FUNC == FN_CLRERR) begin
            err_q <= '0;
          end
        end
        ST_WRITE: begin
          adr_q  <= adr_q + 12'd1;
          mask_q <= '0;
`ifdef CRAM_LOADER_VERIFY_EN
          state_q <= ST_VWAIT;
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_VWAIT: state_q <= ST_VCMP;
        ST_VCMP: begin
`ifdef CRAM_LOADER_VERIFY_EN
          if (CRAM_DOUTB != word_q) err_q[ERR_VERIFY] <= 1'b1;
`endif
          state_q <= ST_IDLE;
        end
        ST_RWAIT: state_q <= ST_RDONE;
        ST_RDONE: begin
          field_q <= CRAM_DOUTB[sel_q*FIELD_WIDTH +: FIELD_WIDTH];
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/cram_loader.md
CRAM_LOADER -- requirements
Module: cram_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port DIAG_FUNC, input, 7 bits: diagnostic function code, sampled when DIAG_STROBE=1.
REQ-004 SHALL have port DIAG_STROBE, input, 1 bit: one-cycle command strobe.
REQ-005 SHALL have port EBUS_D, input, 36 bits [0:35]: write data from the EBUS.
REQ-006 SHALL have port EBUS_D_OUT, output, 36 bits [0:35]: readback data; field in [22:35], zeros in [0:21].
REQ-007 SHALL have port EBUS_VALID, output, 1 bit: one-cycle pulse marking EBUS_D_OUT valid.
REQ-008 SHALL have port CRAM_ADDRB, output, 12 bits: CRAM port-B address.
REQ-009 SHALL have port CRAM_DINB, output, 84 bits [0:83]: CRAM port-B write word.
REQ-010 SHALL have port CRAM_WEB, output, 1 bit: CRAM port-B write enable.
REQ-011 SHALL have port CRAM_DOUTB, input, 84 bits [0:83]: CRAM port-B read word, valid 1 cycle after the address is presented.
REQ-012 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port ERR, output, 3 bits: sticky flags {VERIFY, PARTIAL, OVERRUN}.

Function
REQ-014 SHALL decode 050 (LDADR): ADR <= EBUS_D[24:35]; clears the field mask.
REQ-015 SHALL decode 051-056 (LDFLD k=0..5): word bits [14k:14k+13] <= EBUS_D[22:35]; sets mask bit k.
REQ-016 SHALL decode 057 (WRITE): if mask = 6'b111111, enter WRITE; otherwise set ERR.PARTIAL, perform no write, and stay in IDLE.
REQ-017 SHALL in WRITE drive CRAM_WEB=1 for exactly one cycle with CRAM_ADDRB=ADR and CRAM_DINB=word, then increment ADR modulo 4096 (7777 wraps to 0000) and clear the mask.
REQ-018 SHALL decode 060-065 (RDFLD k): present ADR, wait 1 cycle (RWAIT), then pulse EBUS_VALID with CRAM_DOUTB[14k:14k+13] on EBUS_D_OUT[22:35]; ADR is unchanged.
REQ-019 SHALL decode 066 (CLRERR): ERR <= 0.
REQ-020 SHALL ignore undefined function codes with no state change.
REQ-021 SHALL accept commands only in IDLE; a strobe while BUSY=1 sets ERR.OVERRUN and is otherwise discarded.
REQ-022 SHALL have FSM states IDLE, WRITE, VWAIT, VCMP, RWAIT, RDONE; a write returns to IDLE in 1 cycle (3 cycles with verify, REQ-027); a read returns to IDLE in 2 cycles.
REQ-023 SHALL hold CRAM_WEB=0 in every state except WRITE.
REQ-024 SHALL give ERR.OVERRUN priority when a strobe and an internal error occur in the same cycle; both flags set.

Reset
REQ-025 SHALL, on reset_n=0 and independent of clk, clear: state=IDLE, ADR=0, word=0, mask=0, ERR=0, CRAM_WEB=0, EBUS_VALID=0, EBUS_D_OUT=0.
REQ-026 SHALL on reset mid-write or mid-read abandon the operation; no further CRAM_WEB pulse is issued after reset deasserts.

Configuration
REQ-027 SHALL, with CRAM_LOADER_VERIFY_EN defined, follow WRITE with VWAIT (re-read ADR-before-increment) and VCMP (compare CRAM_DOUTB to word; mismatch sets ERR.VERIFY). Without the macro, WRITE returns directly to IDLE and ERR.VERIFY is tied to 0.

Structure
REQ-028 SHALL take the function-code constants, CRAM_WIDTH=84, FIELD_WIDTH=14, and the state enum from shared package kl10_cram_pkg.
REQ-029 SHALL be a single module with no sub-modules; field insert/extract is inline logic.

Verification
REQ-030 SHALL cover: LDADR 0100, LDFLD 0-5 with 14'o12345, WRITE -> one CRAM_WEB pulse at 0100 with DINB = six repeats of 12345; ADR = 0101.
REQ-031 SHALL cover: LDADR 7777, all fields loaded, WRITE -> write at 7777; then RDFLD 0 reads address 0000.
REQ-032 SHALL cover: LDADR 0200, LDFLD 0-4 only, WRITE -> no CRAM_WEB, ERR=3'b010; CLRERR -> ERR=0.
REQ-033 SHALL cover: strobe during RWAIT -> ERR.OVERRUN=1; the read still completes with one EBUS_VALID pulse.
REQ-034 SHALL cover: with VERIFY_EN, memory model corrupts bit 40 -> ERR.VERIFY=1 three cycles after the WRITE strobe.
REQ-035 SHALL cover: reset_n asserted in the WRITE cycle -> all outputs zero asynchronously; state=IDLE after release.
